// File: rtl/input_debounce_pkg.sv
// Shared types and defaults for the input debouncer.
package input_debounce_pkg;

    // Per-bit debounce FSM: output agrees with sample, or a candidate change is being timed
    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } db_state_t;

    // 20 ms at a 50 MHz fabric clock
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;

endpackage

// File: rtl/input_debounce_bit.sv
// One debounced channel: 2-flop synchronizer, stable/counting FSM, registered edge pulse.
module debounce_bit
    import input_debounce_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic RESET_LEVEL     = 1'b0,
    // 1: pulse only on a debounced 1->0 edge; 0: pulse on either edge
    parameter bit   PULSE_ON_FALL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [1:0]    sync_q;
    logic          s;
    db_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q, db_d;
    logic          pulse_q, pulse_d;

    assign s = sync_q[1];

    // Synchronizer; reset to the idle level so reset never looks like an edge
    always_ff @(posedge clk) begin
        if (reset) sync_q <= {2{RESET_LEVEL}};
        else       sync_q <= {sync_q[0], raw};
    end

    // State, counter, debounced value and pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            db_q    <= RESET_LEVEL;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            pulse_q <= pulse_d;
        end
    end

    // Next state: count consecutive differing samples; commit when the count reaches the limit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_STABLE: begin
                cnt_d = '0;
                if (s != db_q) begin
                    state_d = ST_COUNTING;
                    cnt_d   = CW'(1);
                end
            end
            ST_COUNTING: begin
                if (s == db_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    // Counter stops at CNT_MAX, so it can never wrap
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                    db_d    = s;
                    pulse_d = PULSE_ON_FALL ? ~s : 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    assign db    = db_q;
    assign pulse = pulse_q;

endmodule

// File: rtl/input_debounce.sv
// Debouncer for active-low push-buttons and slide switches feeding the PIO exports.
module input_debounce
    import input_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int N_KEY           = 4,
    parameter int N_SW            = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_KEY-1:0] key_n_in,
    input  logic [N_SW-1:0]  sw_in,
    output logic [N_KEY-1:0] key_db_n,
    output logic [N_SW-1:0]  sw_db,
    output logic [N_KEY-1:0] key_press,
    output logic [N_SW-1:0]  sw_change
);

    // Buttons idle high and only report presses
    for (genvar i = 0; i < N_KEY; i++) begin : g_key
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (1'b1),
            .PULSE_ON_FALL   (1'b1)
        ) u_bit (
            .clk   (clk),
            .reset (reset),
            .raw   (key_n_in[i]),
            .db    (key_db_n[i]),
            .pulse (key_press[i])
        );
    end

    // Switches idle low and report every change
    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (1'b0),
            .PULSE_ON_FALL   (1'b0)
        ) u_bit (
            .clk   (clk),
            .reset (reset),
            .raw   (sw_in[i]),
            .db    (sw_db[i]),
            .pulse (sw_change[i])
        );
    end

endmodule
